coherence_bus_ctrl: RTL and testbench

- Shared-bus / main-memory end of the MSI snooping protocol that each core's data cache drives.
- Accepts miss and invalidate requests from NCORES caches and grants one at a time, round-robin.
- Broadcasts the granted request to all other caches and collects their abort and intervention data.
- Returns the line either from the owning cache or from a 16-word main memory with fixed latency.
- Absorbs write-backs from caches and from snoop-side evictions.

---
 rtl/coh_pkg.sv | 28 ++
 rtl/rr_arbiter.sv | 31 +++
 rtl/coherence_bus_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_coherence_bus_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coh_pkg.sv
// Shared types for the MSI snooping bus controller.
// Bus opcodes, MSI line states, widths and FSM states.
package coh_pkg;

  localparam int COH_AW = 4;
  localparam int COH_DW = 32;

  typedef enum logic [1:0] {
    OP_INV   = 2'b00,
    OP_WMISS = 2'b01,
    OP_RMISS = 2'b10,
    OP_NONE  = 2'b11
  } bus_op_t;

  typedef enum logic [1:0] {
    MSI_I = 2'b00,
    MSI_M = 2'b01,
    MSI_S = 2'b10
  } msi_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SNOOP,
    ST_MEMWAIT,
    ST_RESP
  } st_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr_i.
// Returns one-hot grant, its index and an any-request flag.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] idx_o,
  output logic          any_o
);

  // scan from the pointer, wrapping, keep the first hit
  always_comb begin
    int j;
    j     = 0;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr_i) + k) % N;
      if (!any_o && req_i[j]) begin
        any_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = PW'(j);
      end
    end
  end

endmodule

// File: rtl/coherence_bus_ctrl.sv
// Shared-bus / main-memory end of the MSI snooping protocol.
// One transaction at a time: arbitrate, snoop, memory or intervention, respond.
module coherence_bus_ctrl
  import coh_pkg::*;
#(
  parameter int NCORES  = 2,
  parameter int MEM_LAT = 3,
  parameter int AW      = COH_AW,
  parameter int DW      = COH_DW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCORES-1:0]    req_valid,
  input  logic [2*NCORES-1:0]  req_type,
  input  logic [AW*NCORES-1:0] req_addr,
  input  logic [NCORES-1:0]    wb_valid,
  input  logic [AW*NCORES-1:0] wb_addr,
  input  logic [DW*NCORES-1:0] wb_data,
  input  logic [NCORES-1:0]    snoop_abort,
  input  logic [DW*NCORES-1:0] snoop_data,
  output logic [NCORES-1:0]    grant,
  output logic                 snoop_valid,
  output logic [1:0]           snoop_type,
  output logic [AW-1:0]        snoop_addr,
  output logic [NCORES-1:0]    snoop_src,
  output logic [NCORES-1:0]    resp_valid,
  output logic [DW-1:0]        resp_data,
  output logic                 resp_from_cache
);

  localparam int PW    = (NCORES > 1) ? $clog2(NCORES) : 1;
  localparam int DEPTH = 1 << AW;

  st_e               state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     gidx_q, gidx_d;
  logic [NCORES-1:0] gnt_q, gnt_d;
  bus_op_t           type_q, type_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DW-1:0]     data_q, data_d;
  logic              fc_q, fc_d;

  logic [DW-1:0]     mem_q [DEPTH];

  logic [NCORES-1:0] elig;
  logic [NCORES-1:0] arb_gnt;
  logic [PW-1:0]     arb_idx;
  logic              arb_any;
  logic [NCORES-1:0] abort_m;
  logic              iv_hit;
  logic [DW-1:0]     iv_data;
  logic              fwd_hit;
  logic [DW-1:0]     fwd_data;
  logic              iv_wr;

  // cores with a real request pending
  always_comb begin
    elig = '0;
    for (int i = 0; i < NCORES; i++)
      elig[i] = req_valid[i] &&
                (req_type[2*i +: 2] != OP_NONE);
  end

  rr_arbiter #(.N(NCORES), .PW(PW)) u_arb (
    .req_i (elig),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  assign abort_m = snoop_abort & ~gnt_q;

  // lowest-index aborting cache supplies the line
  always_comb begin
    iv_hit  = 1'b0;
    iv_data = '0;
    for (int i = NCORES - 1; i >= 0; i--) begin
      if (abort_m[i]) begin
        iv_hit  = 1'b1;
        iv_data = snoop_data[DW*i +: DW];
      end
    end
  end

  // same-cycle write-back to the line being read; highest index wins
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < NCORES; i++) begin
      if (wb_valid[i] && wb_addr[AW*i +: AW] == addr_q) begin
        fwd_hit  = 1'b1;
        fwd_data = wb_data[DW*i +: DW];
      end
    end
  end

  assign iv_wr = (state_q == ST_SNOOP) &&
                 (type_q != OP_INV) && iv_hit;

  // transaction sequencing
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    gnt_d   = gnt_q;
    type_d  = type_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    fc_d    = fc_q;
    unique case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          gnt_d   = arb_gnt;
          gidx_d  = arb_idx;
          type_d  = bus_op_t'(
            req_type[2*int'(arb_idx) +: 2]);
          addr_d  = req_addr[AW*int'(arb_idx) +: AW];
          data_d  = '0;
          fc_d    = 1'b0;
          state_d = ST_SNOOP;
        end
      end
      ST_SNOOP: begin
        if (type_q == OP_INV) begin
          data_d  = '0;
          fc_d    = 1'b0;
          state_d = ST_RESP;
        end else if (iv_hit) begin
          data_d  = iv_data;
          fc_d    = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d   = 4'(MEM_LAT - 1);
          state_d = ST_MEMWAIT;
        end
      end
      ST_MEMWAIT: begin
        if (cnt_q == 4'd0) begin
          data_d  = fwd_hit ? fwd_data
                            : mem_q[addr_q];
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        gnt_d   = '0;
        ptr_d   = (gidx_q == PW'(NCORES - 1))
                  ? '0 : gidx_q + 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // control state, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      gidx_q  <= '0;
      gnt_q   <= '0;
      type_q  <= OP_NONE;
      addr_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      fc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      gnt_q   <= gnt_d;
      type_q  <= type_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      fc_q    <= fc_d;
    end
  end

  // memory: intervention first, then write-backs in core order
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (iv_wr)
        mem_q[addr_q] <= iv_data;
      for (int i = 0; i < NCORES; i++)
        if (wb_valid[i])
          mem_q[wb_addr[AW*i +: AW]] <=
            wb_data[DW*i +: DW];
    end
  end

  assign grant = (state_q == ST_IDLE) ? arb_gnt
                                      : gnt_q;

  assign snoop_valid = (state_q == ST_SNOOP);
  assign snoop_type  = snoop_valid ? type_q : OP_NONE;
  assign snoop_addr  = snoop_valid ? addr_q : '0;
  assign snoop_src   = snoop_valid ? gnt_q : '0;

  assign resp_valid      = (state_q == ST_RESP)
                           ? gnt_q : '0;
  assign resp_data       = (state_q == ST_RESP)
                           ? data_q : '0;
  assign resp_from_cache = (state_q == ST_RESP) && fc_q;

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Scoreboard bench for coherence_bus_ctrl, NCORES=2, MEM_LAT=3.
// Stimulus pushes expected snoops/responses; a monitor checks them.
module tb_coherence_bus_ctrl;

  localparam int N = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req_valid;
  logic [3:0]    req_type;
  logic [7:0]    req_addr;
  logic [1:0]    wb_valid;
  logic [7:0]    wb_addr;
  logic [63:0]   wb_data;
  logic [1:0]    snoop_abort;
  logic [63:0]   snoop_data;
  logic [1:0]    grant;
  logic          snoop_valid;
  logic [1:0]    snoop_type;
  logic [3:0]    snoop_addr;
  logic [1:0]    snoop_src;
  logic [1:0]    resp_valid;
  logic [31:0]   resp_data;
  logic          resp_from_cache;

  coherence_bus_ctrl #(.NCORES(N), .MEM_LAT(3)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_type        (req_type),
    .req_addr        (req_addr),
    .wb_valid        (wb_valid),
    .wb_addr         (wb_addr),
    .wb_data         (wb_data),
    .snoop_abort     (snoop_abort),
    .snoop_data      (snoop_data),
    .grant           (grant),
    .snoop_valid     (snoop_valid),
    .snoop_type      (snoop_type),
    .snoop_addr      (snoop_addr),
    .snoop_src       (snoop_src),
    .resp_valid      (resp_valid),
    .resp_data       (resp_data),
    .resp_from_cache (resp_from_cache)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  core;
    logic [31:0] data;
    logic        fc;
    int          cyc;
  } resp_t;

  typedef struct {
    logic [1:0] typ;
    logic [3:0] addr;
    logic [1:0] src;
    int         cyc;
  } snp_t;

  resp_t rq[$];
  snp_t  sq[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // response monitor
  always @(negedge clk) begin
    resp_t e;
    if (resp_valid != 2'b00) begin
      checks++;
      if (rq.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected got core=%b data=%h",
                 resp_valid, resp_data);
      end else begin
        e = rq.pop_front();
        if (resp_valid !== e.core || resp_data !== e.data ||
            resp_from_cache !== e.fc || cyc != e.cyc) begin
          errors++;
          $display("FAIL resp got core=%b data=%h fc=%b cyc=%0d exp core=%b data=%h fc=%b cyc=%0d",
                   resp_valid, resp_data, resp_from_cache, cyc,
                   e.core, e.data, e.fc, e.cyc);
        end
      end
    end
  end

  // snoop broadcast monitor
  always @(negedge clk) begin
    snp_t e;
    if (snoop_valid) begin
      checks++;
      if (sq.size() == 0) begin
        errors++;
        $display("FAIL snoop_unexpected got type=%b addr=%h",
                 snoop_type, snoop_addr);
      end else begin
        e = sq.pop_front();
        if (snoop_type !== e.typ || snoop_addr !== e.addr ||
            snoop_src !== e.src || cyc != e.cyc) begin
          errors++;
          $display("FAIL snoop got type=%b addr=%h src=%b cyc=%0d exp type=%b addr=%h src=%b cyc=%0d",
                   snoop_type, snoop_addr, snoop_src, cyc,
                   e.typ, e.addr, e.src, e.cyc);
        end
      end
    end
  end

  task automatic check_idle(input string nm);
    logic [45:0] got;
    logic [45:0] exp;
    got = {grant, snoop_valid, snoop_type, snoop_addr,
           snoop_src, resp_valid, resp_data, resp_from_cache};
    exp = {2'b00, 1'b0, 2'b11, 4'h0, 2'b00, 2'b00,
           32'h0, 1'b0};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, got, exp);
    end
  endtask

  task automatic wait_grant(input int c, output int g);
    bit ok;
    ok = 1'b0;
    g  = 0;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk);
      if (grant[c]) begin
        ok = 1'b1;
        g  = cyc;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL grant_timeout core=%0d got %b exp bit set",
               c, grant);
    end else if (grant !== (2'b01 << c)) begin
      errors++;
      $display("FAIL grant_onehot got %b exp %b",
               grant, 2'b01 << c);
    end
  endtask

  task automatic wait_resp(input int c);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk);
      if (resp_valid[c]) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout core=%0d got none exp resp", c);
    end
  endtask

  task automatic do_txn(input int c, input logic [1:0] typ,
                        input logic [3:0] addr,
                        input logic [1:0] ab,
                        input logic [63:0] sd,
                        input logic [31:0] ed,
                        input logic efc, input int lat);
    int g;
    @(posedge clk); #1;
    snoop_abort = ab;
    snoop_data  = sd;
    req_valid[c] = 1'b1;
    req_type[2*c +: 2] = typ;
    req_addr[4*c +: 4] = addr;
    wait_grant(c, g);
    sq.push_back('{typ, addr, 2'b01 << c, g + 1});
    rq.push_back('{2'b01 << c, ed, efc, g + lat});
    wait_resp(c);
    @(posedge clk); #1;
    req_valid[c] = 1'b0;
    req_type[2*c +: 2] = 2'b11;
    snoop_abort = 2'b00;
    snoop_data  = '0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    req_valid = 2'b00;
    req_type  = 4'hF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    int g;
    rst = 1'b1;
    req_valid = 2'b00;
    req_type  = 4'hF;
    req_addr  = '0;
    wb_valid  = 2'b00;
    wb_addr   = '0;
    wb_data   = '0;
    snoop_abort = 2'b00;
    snoop_data  = '0;
    for (int i = 0; i < 16; i++)
      dut.mem_q[i] = 32'h1000_0000 + i;
    dut.mem_q[5] = 32'hDEAD_BEEF;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle("reset_state");

    // simultaneous requests after reset, held: 0,1,0,1
    @(posedge clk); #1;
    req_valid = 2'b11;
    req_type  = {2'b10, 2'b10};
    req_addr  = {4'hD, 4'hC};
    for (int t = 0; t < 4; t++) begin
      int c;
      c = t % 2;
      wait_grant(c, g);
      sq.push_back('{2'b10, (c == 0) ? 4'hC : 4'hD,
                     2'b01 << c, g + 1});
      rq.push_back('{2'b01 << c,
                     (c == 0) ? 32'h1000_000C : 32'h1000_000D,
                     1'b0, g + 5});
      wait_resp(c);
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
    req_type  = 4'hF;

    // fresh reset so the pointer is at core 0
    do_reset();

    // core0 read miss from memory
    do_txn(0, 2'b10, 4'h5, 2'b00, 64'h0,
           32'hDEAD_BEEF, 1'b0, 5);
    // core1 read miss, core0 intervenes
    do_txn(1, 2'b10, 4'h9, 2'b01, {32'h0, 32'h1234_5678},
           32'h1234_5678, 1'b1, 2);
    // intervention updated memory
    do_txn(0, 2'b10, 4'h9, 2'b00, 64'h0,
           32'h1234_5678, 1'b0, 5);
    // requester's own abort is masked
    do_txn(0, 2'b10, 4'h2, 2'b01, {32'h0, 32'hBAD0_0001},
           32'h1000_0002, 1'b0, 5);
    // write miss served by core1
    do_txn(0, 2'b01, 4'h7, 2'b10, {32'hCAFE_F00D, 32'h0},
           32'hCAFE_F00D, 1'b1, 2);
    // invalidate: no data even with an abort present
    do_txn(0, 2'b00, 4'h3, 2'b10, {32'hFFFF_FFFF, 32'h0},
           32'h0, 1'b0, 2);

    // write-back forwarding into the memory capture cycle
    @(posedge clk); #1;
    req_valid[0] = 1'b1;
    req_type[1:0] = 2'b10;
    req_addr[3:0] = 4'h5;
    wait_grant(0, g);
    sq.push_back('{2'b10, 4'h5, 2'b01, g + 1});
    rq.push_back('{2'b01, 32'hA5A5_A5A5, 1'b0, g + 5});
    repeat (4) @(posedge clk);
    #1;
    wb_valid = 2'b10;
    wb_addr  = {4'h5, 4'h0};
    wb_data  = {32'hA5A5_A5A5, 32'h0};
    @(posedge clk); #1;
    wb_valid = 2'b00;
    wait_resp(0);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    req_type[1:0] = 2'b11;
    do_txn(1, 2'b10, 4'h5, 2'b00, 64'h0,
           32'hA5A5_A5A5, 1'b0, 5);

    // write-back collision: higher core index wins
    @(posedge clk); #1;
    wb_valid = 2'b11;
    wb_addr  = {4'hA, 4'hA};
    wb_data  = {32'h2222_2222, 32'h1111_1111};
    @(posedge clk); #1;
    wb_valid = 2'b00;
    do_txn(0, 2'b10, 4'hA, 2'b00, 64'h0,
           32'h2222_2222, 1'b0, 5);

    // reset during MEMWAIT drops the response
    @(posedge clk); #1;
    req_valid[0] = 1'b1;
    req_type[1:0] = 2'b10;
    req_addr[3:0] = 4'h6;
    wait_grant(0, g);
    sq.push_back('{2'b10, 4'h6, 2'b01, g + 1});
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    req_valid = 2'b00;
    req_type  = 4'hF;
    wb_valid  = 2'b01;
    wb_addr   = {4'h0, 4'h6};
    wb_data   = {32'h0, 32'hBAD0_BAD0};
    @(posedge clk); #1;
    rst = 1'b0;
    wb_valid = 2'b00;
    @(negedge clk);
    check_idle("after_mid_reset");
    do_txn(1, 2'b10, 4'h6, 2'b00, 64'h0,
           32'h1000_0006, 1'b0, 5);

    repeat (10) @(posedge clk);
    checks++;
    if (rq.size() != 0 || sq.size() != 0) begin
      errors++;
      $display("FAIL queues_drained got resp=%0d snoop=%0d exp 0",
               rq.size(), sq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
